maze_game_core: RTL and testbench

MAZE_GAME_CORE -- requirements
Module: maze_game_core

---
 rtl/maze_game_core.sv | 171 +++++++++++++++++
 tb/tb_maze_game_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_game_core.sv
// rtl/maze_game_core.sv - maze player movement, cell scoring and completion (optional timer: MAZE_TIMER_EN)
module maze_game_core #(
  parameter int GRID_W        = 10,
  parameter int GRID_H        = 15,
  parameter int CELL_BITS     = 5,
  parameter int SPEED         = 4,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int START_SCORE   = 150,
  localparam int XW = $clog2(GRID_W) + CELL_BITS,
  localparam int YW = $clog2(GRID_H) + CELL_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [3:0]                         btn,
  input  logic [(GRID_H+1)*GRID_W-1:0]       h_walls,
  input  logic [GRID_H*(GRID_W+1)-1:0]       v_walls,
  input  logic [2*GRID_W*GRID_H-1:0]         food,
  output logic [XW-1:0]                      pos_x,
  output logic [YW-1:0]                      pos_y,
  output logic [1:0]                         direction,
  output logic [15:0]                        score,
  output logic [15:0]                        final_score,
  output logic                               done
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int CW    = $clog2(SPEED + 1);
  localparam logic [XW-1:0] X_MAX = XW'((GRID_W - 1) << CELL_BITS);
  localparam logic [YW-1:0] Y_MAX = YW'((GRID_H - 1) << CELL_BITS);

  logic [3:0]       btn_q;
  logic [CW-1:0]    step_cnt;
  logic [NCELL-1:0] visited;
  logic             tick;
  logic             aligned;
  int               cx;
  int               cy;
  int               cell_idx;
  logic [3:0]       free;
  logic             vis_bit;
  logic [1:0]       food_code;
  logic [16:0]      score_sum;
  logic [1:0]       new_dir;
  logic             move;
  logic [XW-1:0]    nx;
  logic [YW-1:0]    ny;
  logic [15:0]      final_calc;

  assign tick    = (step_cnt == '0) && enable && !done;
  assign aligned = (pos_x[CELL_BITS-1:0] == '0) && (pos_y[CELL_BITS-1:0] == '0);

  // Decode current cell, the wall around it, its food and visited state
  always_comb begin
    logic [GRID_H*(GRID_W+1)-1:0] v_sh0;
    logic [GRID_H*(GRID_W+1)-1:0] v_sh2;
    logic [(GRID_H+1)*GRID_W-1:0] h_sh1;
    logic [(GRID_H+1)*GRID_W-1:0] h_sh3;
    logic [NCELL-1:0]             vis_sh;
    logic [2*NCELL-1:0]           food_sh;
    cx        = int'(pos_x[XW-1:CELL_BITS]);
    cy        = int'(pos_y[YW-1:CELL_BITS]);
    cell_idx  = cy * GRID_W + cx;
    v_sh0     = v_walls >> (cy * (GRID_W + 1) + cx + 1);
    h_sh1     = h_walls >> ((cy + 1) * GRID_W + cx);
    v_sh2     = v_walls >> (cy * (GRID_W + 1) + cx);
    h_sh3     = h_walls >> (cy * GRID_W + cx);
    free      = {~h_sh3[0], ~v_sh2[0], ~h_sh1[0], ~v_sh0[0]};
    vis_sh    = visited >> cell_idx;
    vis_bit   = vis_sh[0];
    food_sh   = food >> (2 * cell_idx);
    food_code = food_sh[1:0];
    score_sum = {1'b0, score} + (17'd1 << (2 * food_code));
  end

  // Choose heading and next pixel position; lowest free pressed button wins, edges clamp
  always_comb begin
    new_dir = direction;
    move    = 1'b1;
    nx      = pos_x;
    ny      = pos_y;
    if (aligned) begin
      for (int i = 3; i >= 0; i--) begin
        if (btn_q[i] && free[i]) new_dir = 2'(i);
      end
      move = free[new_dir];
    end
    if (move) begin
      case (new_dir)
        2'd0: if (pos_x < X_MAX) nx = pos_x + 1'b1;
        2'd1: if (pos_y < Y_MAX) ny = pos_y + 1'b1;
        2'd2: if (pos_x != '0)   nx = pos_x - 1'b1;
        default: if (pos_y != '0) ny = pos_y - 1'b1;
      endcase
    end
  end

  // Buttons are registered once before any decision uses them
  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn;
  end

  // Step divider counts down and wraps; held while disabled
  always_ff @(posedge clk) begin
    if (rst)                step_cnt <= CW'(SPEED - 1);
    else if (enable)        step_cnt <= (step_cnt == '0) ? CW'(SPEED - 1) : step_cnt - 1'b1;
  end

  // Player position and heading advance only on step ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x     <= '0;
      pos_y     <= '0;
      direction <= 2'd2;
    end else if (tick) begin
      pos_x     <= nx;
      pos_y     <= ny;
      direction <= new_dir;
    end
  end

  // First aligned visit of a cell marks it and adds its food value, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      visited <= '0;
      score   <= 16'(START_SCORE);
    end else if (enable && !done && aligned && !vis_bit) begin
      visited <= visited | ({{(NCELL-1){1'b0}}, 1'b1} << cell_idx);
      score   <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // Completion flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst)             done <= 1'b0;
    else if (&visited)   done <= 1'b1;
  end

`ifdef MAZE_TIMER_EN
  localparam int TW = $clog2(TICKS_PER_SEC + 1);
  logic [TW-1:0] sec_cnt;
  logic [15:0]   seconds;

  // Elapsed-seconds counter over enabled, unfinished cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt <= '0;
      seconds <= '0;
    end else if (enable && !done) begin
      if (sec_cnt == TW'(TICKS_PER_SEC - 1)) begin
        sec_cnt <= '0;
        if (seconds != 16'hFFFF) seconds <= seconds + 1'b1;
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end

  assign final_calc = (score > seconds) ? score - seconds : 16'd0;
`else
  assign final_calc = score;
`endif

  // Displayed score tracks until the maze is finished, then holds
  always_ff @(posedge clk) begin
    if (rst)        final_score <= '0;
    else if (!done) final_score <= final_calc;
  end

endmodule

// File: tb/tb_maze_game_core.sv
// tb/tb_maze_game_core.sv - scoreboard bench for maze_game_core
module tb_maze_game_core;

  localparam int W   = 10;
  localparam int H   = 15;
  localparam int CB  = 5;
  localparam int TPS = 100;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      enable = 1'b1;
  logic [3:0]                btn = 4'b0000;
  logic [(H+1)*W-1:0]        h_walls;
  logic [H*(W+1)-1:0]        v_walls;
  logic [2*W*H-1:0]          food;
  logic [8:0]                pos_x;
  logic [8:0]                pos_y;
  logic [1:0]                direction;
  logic [15:0]               score;
  logic [15:0]               final_score;
  logic                      done;

  int n_cmp  = 0;
  int n_fail = 0;
  int sb_q[$];
  logic [15:0] prev_score;

  maze_game_core #(
    .GRID_W(W), .GRID_H(H), .CELL_BITS(CB), .SPEED(4),
    .TICKS_PER_SEC(TPS), .START_SCORE(150)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .h_walls(h_walls), .v_walls(v_walls), .food(food),
    .pos_x(pos_x), .pos_y(pos_y), .direction(direction),
    .score(score), .final_score(final_score), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cell_val(input int x, input int y);
    return 1 << (2 * ((x + 2 * y + 2) % 4));
  endfunction

  function automatic int exp_final(input int s, input int n);
`ifdef MAZE_TIMER_EN
    int secs;
    secs = (n - 1) / TPS;
    return (s > secs) ? s - secs : 0;
`else
    return s + 0 * n;
`endif
  endfunction

  task automatic set_border();
    h_walls = '0;
    v_walls = '0;
    for (int x = 0; x < W; x++) begin
      h_walls[x] = 1'b1;
      h_walls[H*W + x] = 1'b1;
    end
    for (int y = 0; y < H; y++) begin
      v_walls[y*(W+1)] = 1'b1;
      v_walls[y*(W+1) + W] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    sb_q.delete();
    sb_q.push_back(150 + cell_val(0, 0));
    rst = 1'b0;
  endtask

  // Score monitor: every score change must match the next queued expectation
  always @(negedge clk) begin
    if (rst) begin
      prev_score = score;
    end else if (score !== prev_score) begin
      if (sb_q.size() == 0) check("sb_unexpected_score", int'(score), -1);
      else                  check("score", int'(score), sb_q.pop_front());
      prev_score = score;
    end
  end

  initial begin
    int total;
    int n;
    bit early;
    for (int i = 0; i < W*H; i++) food[2*i +: 2] = 2'((i % W + 2 * (i / W) + 2) % 4);
    set_border();

    // reset values and first-cell scoring
    do_reset();
    check("rst_score", int'(score), 150);
    check("rst_final", int'(final_score), 0);
    check("rst_dir", int'(direction), 2);
    check("rst_done", int'(done), 0);
    cycles(2);
    check("final_follow", int'(final_score), 166);
    cycles(20);
    check("idle_pos_x", int'(pos_x), 0);
    check("idle_pos_y", int'(pos_y), 0);
    check("idle_dir", int'(direction), 2);

    // clamp at origin with border walls removed
    v_walls[0] = 1'b0;
    h_walls[0] = 1'b0;
    btn = 4'b0100;
    cycles(20);
    check("clamp_x", int'(pos_x), 0);
    check("clamp_dir2", int'(direction), 2);
    btn = 4'b1000;
    cycles(20);
    check("clamp_y", int'(pos_y), 0);
    check("clamp_dir3", int'(direction), 3);
    check("sb_drain_clamp", sb_q.size(), 0);
    set_border();

    // move right one cell, freeze while disabled
    btn = 4'b0000;
    do_reset();
    sb_q.push_back(166 + cell_val(1, 0));
    btn = 4'b0001;
    cycles(4);
    check("right_px1", int'(pos_x), 1);
    check("right_dir", int'(direction), 0);
    cycles(124);
    check("right_px32", int'(pos_x), 32);
    check("right_py", int'(pos_y), 0);
    cycles(1);
    enable = 1'b0;
    cycles(20);
    check("freeze_px", int'(pos_x), 32);
    enable = 1'b1;
    cycles(3);
    check("resume_px", int'(pos_x), 33);
    check("sb_drain_right", sb_q.size(), 0);

    // wall to the right: falls through to +y
    btn = 4'b0000;
    v_walls[1] = 1'b1;
    do_reset();
    btn = 4'b0011;
    cycles(8);
    check("wall_dir", int'(direction), 1);
    check("wall_py", int'(pos_y), 2);
    check("wall_px", int'(pos_x), 0);
    check("sb_drain_wall", sb_q.size(), 0);
    v_walls[1] = 1'b0;

    // long idle run for the displayed score
    btn = 4'b0000;
    do_reset();
    cycles(1005);
    check("timer_final", int'(final_score), exp_final(166, 1005));
    check("sb_drain_timer", sb_q.size(), 0);

    // serpentine through every cell
    do_reset();
    total = 166;
    for (int y = 0; y < H; y++) begin
      for (int k = 0; k < W; k++) begin
        int x;
        x = (y % 2 == 0) ? k : W - 1 - k;
        if (!(x == 0 && y == 0)) begin
          total += cell_val(x, y);
          sb_q.push_back(total);
        end
      end
    end
    n = 0;
    early = 1'b0;
    while (n < 25000) begin
      int row;
      int col;
      row = int'(pos_y) >> CB;
      col = int'(pos_x) >> CB;
      if (row % 2 == 0) btn = (col < W - 1) ? 4'b0001 : 4'b0010;
      else              btn = (col > 0)     ? 4'b0100 : 4'b0010;
      cycles(1);
      n++;
      if (sb_q.size() == 0) break;
      if (done) early = 1'b1;
    end
    check("done_set", int'(done), 1);
    check("done_early", int'(early), 0);
    check("done_score", int'(score), total);
    check("done_final", int'(final_score), exp_final(total, n));
    btn = 4'b0100;
    cycles(50);
    check("frozen_px", int'(pos_x), (W - 1) << CB);
    check("frozen_py", int'(pos_y), (H - 1) << CB);
    check("frozen_dir", int'(direction), 0);
    check("frozen_final", int'(final_score), exp_final(total, n));
    check("done_sticky", int'(done), 1);

    // reset from finished state
    rst = 1'b1;
    cycles(1);
    check("rerst_px", int'(pos_x), 0);
    check("rerst_py", int'(pos_y), 0);
    check("rerst_dir", int'(direction), 2);
    check("rerst_score", int'(score), 150);
    check("rerst_final", int'(final_score), 0);
    check("rerst_done", int'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
